// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the IF/ID/EX pipeline sequencer.
// Stage-control bundles are packed structs so the top can select one per cycle.
package pipeline_ctrl_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] SYSCALL_V0_EXIT = 32'd10;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
  } stage_ctl_t;

  // Kill: freeze fetch and squash both latches (reset, exit, drain, halted).
  localparam stage_ctl_t CTL_KILL     = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam stage_ctl_t CTL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
  localparam stage_ctl_t CTL_STALL    = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
  localparam stage_ctl_t CTL_ADVANCE  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the register reads in ID.
// Register 0 is never a real destination, so it can never cause a stall.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_num,
  input  logic [REG_W-1:0] id_rt_num,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_reg_write_num,
  output logic             hz
);

  logic rs_match;
  logic rt_match;
  logic dest_valid;

  assign rs_match   = id_uses_rs && (id_rs_num == ex_reg_write_num);
  assign rt_match   = id_uses_rt && (id_rt_num == ex_reg_write_num);
  assign dest_valid = (ex_reg_write_num != '0);

  assign hz = ex_mem_read && dest_valid && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect flushes, print latch and exit drain/halt.
// Define PIPE_PERF_CNT_EN to build the cycle/stall performance counters; otherwise they read 0.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [REG_W-1:0]  id_rs_num,
  input  logic [REG_W-1:0]  id_rt_num,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_reg_write_num,
  input  logic              ex_redirect,
  input  logic              ex_syscall,
  input  logic [WORD_W-1:0] ex_syscall_v0,
  input  logic [WORD_W-1:0] ex_syscall_a0,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              halted,
  output logic [WORD_W-1:0] display,
  output logic              display_valid,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(1);

  ctrl_state_t        state;
  logic [DRAIN_W-1:0] drain_cnt;
  stage_ctl_t         ctl;
  logic               hz;
  logic               is_exit;
  logic               is_print;

  hazard_detect u_hazard_detect (
    .id_rs_num        (id_rs_num),
    .id_rt_num        (id_rt_num),
    .id_uses_rs       (id_uses_rs),
    .id_uses_rt       (id_uses_rt),
    .ex_mem_read      (ex_mem_read),
    .ex_reg_write_num (ex_reg_write_num),
    .hz               (hz)
  );

  assign is_exit  = ex_syscall && (ex_syscall_v0 == SYSCALL_V0_EXIT);
  assign is_print = ex_syscall && (ex_syscall_v0 != SYSCALL_V0_EXIT);

  // clr is folded in here so the stage controls go to kill without waiting for a clock edge.
  always_comb begin
    ctl = CTL_KILL;
    if (!clr && (state == RUN)) begin
      if (is_exit) begin
        ctl = CTL_KILL;
      end else if (ex_redirect) begin
        ctl = CTL_REDIRECT;
      end else if (hz) begin
        ctl = CTL_STALL;
      end else begin
        ctl = CTL_ADVANCE;
      end
    end
  end

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_flush = ctl.idex_flush;
  assign halted     = (state == HALTED);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= RUN;
      drain_cnt     <= '0;
      display       <= '0;
      display_valid <= 1'b0;
    end else begin
      display_valid <= 1'b0;
      unique case (state)
        RUN: begin
          if (is_exit) begin
            if (DRAIN_CYCLES == 0) begin
              state <= HALTED;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end else if (is_print) begin
            display       <= ex_syscall_a0;
            display_valid <= 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - DRAIN_LAST;
          if (drain_cnt <= DRAIN_LAST) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_q;
  logic             stall_fire;

  // Mirrors the hazard branch of the priority chain so only real bubbles are counted.
  assign stall_fire = (state == RUN) && !is_exit && !ex_redirect && hz;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if ((state != HALTED) && (cycle_q != '1)) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (stall_fire && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule
